// File: rtl/iir_tm.sv
// Time-multiplexed cascade of second-order IIR sections (Direct Form II).
// One section is evaluated per clock over a shared multiply/accumulate datapath.
module iir_tm #(
  parameter int unsigned No_SOS = 4,
  parameter int unsigned WIX    = 3,
  parameter int unsigned WFX    = 7,
  parameter int unsigned WIC    = 2,
  parameter int unsigned WFC    = 8,
  parameter int unsigned WIS    = 5,
  parameter int unsigned WFS    = 11,
  parameter int unsigned WIO    = 8,
  parameter int unsigned WFO    = 18
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [WIX+WFX-1:0]     X,
  output logic [WIO+WFO-1:0]     Y,
  output logic                   IIR_overflow
);

  localparam int unsigned WC  = WIC + WFC;
  localparam int unsigned WS  = WIS + WFS;
  localparam int unsigned WY  = WIO + WFO;
  localparam int unsigned WP  = WS + WC;
  localparam int unsigned WA  = WP + 2;
  localparam int unsigned WR  = WA - WFC;
  localparam int unsigned CW  = (No_SOS > 1) ? $clog2(No_SOS) : 1;
  localparam int unsigned CIW = $clog2(5 * No_SOS);

  localparam logic [CW-1:0] CntLast = CW'(No_SOS - 1);
  localparam logic [WS-1:0] SMax    = {1'b0, {(WS-1){1'b1}}};
  localparam logic [WS-1:0] SMin    = {1'b1, {(WS-1){1'b0}}};

  // Preloaded hierarchically; intentionally never reset or written here.
  logic signed [WC-1:0] filter_coeff [0:5*No_SOS-1];
  logic signed [WC-1:0] scale_coeff  [0:No_SOS-1];

  logic        [CW-1:0] cnt_q;
  logic signed [WS-1:0] s1_q [No_SOS];
  logic signed [WS-1:0] s2_q [No_SOS];
  logic signed [WS-1:0] inter_q;

  logic        [CIW-1:0] base;
  logic signed [WC-1:0]  g, b0, b1, b2, a1, a2;
  logic signed [WS-1:0]  x_ext, u, s1, s2, w, v;
  logic signed [WP-1:0]  p_g, p_a1, p_a2, p_b0, p_b1, p_b2;
  logic signed [WA-1:0]  acc_w, acc_v;
  logic                  w_ovf, v_ovf;
  logic        [WY-1:0]  y_next;

  // Floor the low WFC bits, then clamp to the state range; MSB of result flags clamping.
  function automatic logic [WS:0] reduce(input logic signed [WA-1:0] acc);
    logic [WR-1:0]    r;
    logic [WR-WS:0]   hi;
    r  = acc[WA-1:WFC];
    hi = r[WR-1:WS-1];
    if ((&hi) || !(|hi)) begin
      return {1'b0, r[WS-1:0]};
    end else if (r[WR-1]) begin
      return {1'b1, SMin};
    end else begin
      return {1'b1, SMax};
    end
  endfunction

  always_comb begin
    base  = CIW'(5 * int'(cnt_q));
    g     = scale_coeff[cnt_q];
    b0    = filter_coeff[base];
    b1    = filter_coeff[base + CIW'(1)];
    b2    = filter_coeff[base + CIW'(2)];
    a1    = filter_coeff[base + CIW'(3)];
    a2    = filter_coeff[base + CIW'(4)];
    s1    = s1_q[cnt_q];
    s2    = s2_q[cnt_q];
    x_ext = WS'($signed(X)) <<< (WFS - WFX);
    u     = (cnt_q == '0) ? x_ext : inter_q;

    p_g   = WP'(u)  * WP'(g);
    p_a1  = WP'(s1) * WP'(a1);
    p_a2  = WP'(s2) * WP'(a2);
    acc_w = WA'(p_g) - WA'(p_a1) - WA'(p_a2);
    {w_ovf, w} = reduce(acc_w);

    p_b0  = WP'(w)  * WP'(b0);
    p_b1  = WP'(s1) * WP'(b1);
    p_b2  = WP'(s2) * WP'(b2);
    acc_v = WA'(p_b0) + WA'(p_b1) + WA'(p_b2);
    {v_ovf, v} = reduce(acc_v);

    y_next = WY'(v) <<< (WFO - WFS);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q        <= '0;
      inter_q      <= '0;
      Y            <= '0;
      IIR_overflow <= 1'b0;
      for (int i = 0; i < No_SOS; i++) begin
        s1_q[i] <= '0;
        s2_q[i] <= '0;
      end
    end else begin
      cnt_q         <= (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
      s2_q[cnt_q]   <= s1;
      s1_q[cnt_q]   <= w;
      inter_q       <= v;
      if (cnt_q == CntLast) begin
        Y <= y_next;
      end
      if (w_ovf || v_ovf) begin
        IIR_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iir_tm.sv
// Directed bench for iir_tm: frame-by-frame stimulus with a queue of expected outputs.
module tb_iir_tm;

  localparam logic [9:0] COne   = 10'h100;
  localparam logic [9:0] CHalf  = 10'h080;
  localparam logic [9:0] CQtr   = 10'h040;
  localparam logic [9:0] CmHalf = 10'h380;
  localparam logic [9:0] CmQtr  = 10'h3C0;
  localparam logic [9:0] CMax   = 10'h1FF;

  logic        clk;
  logic        rst;
  logic [9:0]  x;
  logic [25:0] y;
  logic        ovf;

  logic [25:0] sb_q[$];
  logic [25:0] last_y;
  int          n_total;
  int          n_pass;
  int          n_fail;

  iir_tm dut (
    .CLK          (clk),
    .RESET        (rst),
    .X            (x),
    .Y            (y),
    .IIR_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [25:0] got, input logic [25:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sec(input int k, input logic [9:0] g, input logic [9:0] b0,
                         input logic [9:0] b1, input logic [9:0] b2,
                         input logic [9:0] a1, input logic [9:0] a2);
    dut.scale_coeff[k]        = g;
    dut.filter_coeff[5*k]     = b0;
    dut.filter_coeff[5*k + 1] = b1;
    dut.filter_coeff[5*k + 2] = b2;
    dut.filter_coeff[5*k + 3] = a1;
    dut.filter_coeff[5*k + 4] = a2;
  endtask

  task automatic all_pass(input logic [9:0] gain);
    for (int k = 0; k < 4; k++) set_sec(k, gain, gain, '0, '0, '0, '0);
  endtask

  // Called at a falling edge; leaves the bench at the falling edge of the next cnt=0 cycle.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({tag, "_rst_y"}, y, '0);
    check({tag, "_rst_ovf"}, {25'd0, ovf}, 26'd0);
    last_y = '0;
  endtask

  task automatic run_frame(input string tag, input logic [9:0] xin, input logic [25:0] exp_y,
                           input logic exp_ovf, input bit junk);
    logic [25:0] e;
    x = xin;
    sb_q.push_back(exp_y);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i < 3) begin
        check({tag, "_hold"}, y, last_y);
        if (junk) x = 10'($urandom);
      end
    end
    e = sb_q.pop_front();
    check({tag, "_y"}, y, e);
    check({tag, "_ovf"}, {25'd0, ovf}, {25'd0, exp_ovf});
    last_y = e;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst     = 1'b1;
    x       = '0;
    last_y  = '0;

    // Pass-through, with junk on X outside the cnt=0 cycle.
    all_pass(COne);
    do_reset("pass");
    run_frame("pass_p1", 10'h080, 26'h0040000, 1'b0, 1'b0);
    run_frame("pass_m1", 10'h380, 26'h3FC0000, 1'b0, 1'b1);
    run_frame("pass_h",  10'h040, 26'h0020000, 1'b0, 1'b1);

    // First-order recursion in section 0 (a1 = -0.5).
    all_pass(COne);
    set_sec(0, COne, COne, '0, '0, CmHalf, '0);
    do_reset("rec");
    run_frame("rec0", 10'h080, 26'h0040000, 1'b0, 1'b0);
    run_frame("rec1", 10'h000, 26'h0020000, 1'b0, 1'b1);
    run_frame("rec2", 10'h000, 26'h0010000, 1'b0, 1'b1);
    run_frame("rec3", 10'h000, 26'h0008000, 1'b0, 1'b1);

    // Feed-forward taps in section 1.
    all_pass(COne);
    set_sec(1, COne, COne, CHalf, CQtr, '0, '0);
    do_reset("fir");
    run_frame("fir0", 10'h080, 26'h0040000, 1'b0, 1'b0);
    run_frame("fir1", 10'h000, 26'h0020000, 1'b0, 1'b0);
    run_frame("fir2", 10'h000, 26'h0010000, 1'b0, 1'b0);
    run_frame("fir3", 10'h000, 26'h0000000, 1'b0, 1'b0);

    // a2 feedback in section 2, input gain 0.5 in section 3.
    all_pass(COne);
    set_sec(2, COne, COne, '0, '0, '0, CmQtr);
    set_sec(3, CHalf, COne, '0, '0, '0, '0);
    do_reset("a2");
    run_frame("a2_0", 10'h080, 26'h0020000, 1'b0, 1'b0);
    run_frame("a2_1", 10'h000, 26'h0000000, 1'b0, 1'b0);
    run_frame("a2_2", 10'h000, 26'h0008000, 1'b0, 1'b0);
    run_frame("a2_3", 10'h000, 26'h0000000, 1'b0, 1'b0);

    // Saturation: sticky flag survives zero input.
    all_pass(CMax);
    do_reset("sat");
    run_frame("sat0", 10'h1FF, 26'h03FFF80, 1'b1, 1'b0);
    run_frame("sat1", 10'h000, 26'h0000000, 1'b1, 1'b0);

    // Mid-frame reset clears state and the flag.
    all_pass(COne);
    set_sec(0, COne, COne, '0, '0, CmHalf, '0);
    run_frame("mid0", 10'h080, 26'h0040000, 1'b1, 1'b0);
    x = 10'h000;
    @(negedge clk);
    @(negedge clk);
    check("mid_pre_hold", y, last_y);
    do_reset("mid");
    run_frame("mid1", 10'h040, 26'h0020000, 1'b0, 1'b0);
    run_frame("mid2", 10'h000, 26'h0010000, 1'b0, 1'b0);

    // Quantisation: products below 2^-11 floor away (toward minus infinity).
    all_pass(COne);
    set_sec(0, COne, 10'h001, '0, '0, '0, '0);
    do_reset("q");
    run_frame("q_pos", 10'h001, 26'h0000000, 1'b0, 1'b0);
    run_frame("q_neg", 10'h3FF, 26'h3FFFF80, 1'b0, 1'b0);

    check("sb_empty", 26'(sb_q.size()), 26'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/iir_tm.md
Name: iir_tm

Overview:
- Time-multiplexed cascade of No_SOS second-order IIR sections (biquads), using one shared arithmetic datapath.
- The block evaluates one section per clock, so a new input sample is consumed every No_SOS clocks.
- Coefficients live in internal register arrays that the simulation or integration flow preloads; there is no write port.
- Sits in the DSP chain between a fixed-point sample source and downstream consumers.

Parameters:
- No_SOS, 4, number of cascaded second-order sections.
- WIX, 3, input integer bits (including sign).
- WFX, 7, input fraction bits.
- WIC, 2, coefficient integer bits (including sign).
- WFC, 8, coefficient fraction bits.
- WIS, 5, internal state/intermediate integer bits.
- WFS, 11, internal state fraction bits.
- WIO, 8, output integer bits; WIO ≥ WIS is required.
- WFO, 18, output fraction bits; WFO ≥ WFS is required.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- RESET  in  1  synchronous, active-high reset.
- X  in  WIX+WFX  signed two's-complement input sample, Q(WIX).(WFX).
- Y  out  WIO+WFO  signed filter output, Q(WIO).(WFO), registered.
- IIR_overflow  out  1  sticky saturation flag.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RESET).
- Internal arrays, not reset, with exact names because they are loaded hierarchically by binary $readmemb:
  - filter_coeff[0:5*No_SOS-1], width WIC+WFC. Section k occupies entries 5k..5k+4 in the order b0, b1, b2, a1, a2; a0 = 1 is implied.
  - scale_coeff[0:No_SOS-1], width WIC+WFC. Holds the input gain g_k of each section.
- State memory: two delay registers per section, s1[k] and s2[k], each Q(WIS).(WFS).
- Slot counter cnt:
  - Counts 0..No_SOS-1, wraps to 0, and free-runs while RESET=0.
  - RESET=1 at a clock edge forces cnt=0.
- Processing per slot:
  - The cycle with cnt=k evaluates section k combinationally and registers the results at the closing edge.
  - Section input u: for k=0, X sign-extended and zero-padded to Q(WIS).(WFS); otherwise the intermediate register written by section k-1.
  - Direct Form II recursion: w = g_k·u − a1·s1[k] − a2·s2[k]; v = b0·w + b1·s1[k] + b2·s2[k].
  - At the edge: s2[k] ← s1[k], s1[k] ← w, intermediate register ← v.
  - At the edge closing cnt=No_SOS-1, Y ← v converted to the output format (sign-extend integer bits, zero-pad fraction bits).
- Latency and sampling:
  - X is sampled only in the cnt=0 cycle; X must be held stable for that whole cycle, and other cycles ignore X.
  - Y updates No_SOS-1 edges after the edge that closes the cnt=0 cycle, then holds for No_SOS cycles.
- Arithmetic:
  - Products are full precision, Q(WIS+WIC).(WFS+WFC), and sums are accumulated at full width plus 2 guard bits.
  - w and v are reduced to Q(WIS).(WFS) by truncation (floor) of the low WFC fraction bits, then saturated to the signed range (−2^(WIS-1) .. 2^(WIS-1) − 2^-WFS).
- Overflow:
  - Any saturation of w or v sets IIR_overflow at that edge.
  - The flag stays set until RESET.
- Reset:
  - Clears cnt, all s1/s2 registers, the intermediate register, Y, and IIR_overflow.
  - Does not alter the coefficient arrays.
  - A reset mid-frame aborts the frame with no partial Y update; processing restarts at section 0 on the first cycle after RESET falls.

Test Plan:
1. Pass-through setup: all sections have g=b0=0100000000 (1.0) and other coefficients 0. After reset, X=0010000000 (1.0) → Y=1.0 (0x0040000) at the 4th edge; X=1110000000 (−1.0) next frame → Y=−1.0. IIR_overflow stays 0.
2. Recursion check: section 0 has a1=1110000000 (−0.5); other sections are pass-through. Impulse X=1.0 then X=0 → successive frame outputs 1.0, 0.5, 0.25, 0.125 exactly.
3. Timing check: change X in cnt≠0 cycles only → Y is unaffected; Y is stable for exactly 4 cycles between updates.
4. Saturation: every g=b0=1.1111111 (≈1.996); X=0111111111 (≈3.99) → w saturates to 15.99951 and IIR_overflow rises. The flag persists after X returns to 0 and clears only on RESET.
5. Reset mid-frame: assert RESET during cnt=2 → Y=0, state cleared, IIR_overflow=0. Releasing RESET then pass-through X=0.5 → Y=0.5 one frame later with no residue from previous state.
6. Quantisation: single section with g=1.0, b0=0000000001 (2^-8); X=0000000001 (2^-7) → Y=0 (the 2^-15 product is truncated below 2^-11).
